multi_ch_cail: RTL and testbench
================================

MULTI_CH_CAIL -- requirements
Module: multi_ch_cail

Interface
REQ-001 SHALL have parameter CH_NUM, default 8: number of interleaved channels per frame (1..16).
REQ-002 SHALL have parameter DATA_W, default 16: signed input sample width.
REQ-003 SHALL have parameter GAIN_W, default 20: signed gain width, format Q(GAIN_W-FRAC_W).FRAC_W.
REQ-004 SHALL have parameter FRAC_W, default 16: gain fractional bits.
REQ-005 SHALL have parameter OUT_W, default 16: signed saturated output width.
REQ-006 SHALL have port clk, input, 1: clock, all logic on rising edge.
REQ-007 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port start, input, 1: one-cycle burst start request.
REQ-009 SHALL have port frame_len, input, 16: number of frames in the burst, sampled on accepted start.
REQ-010 SHALL have port abort, input, 1: synchronous burst cancel.
REQ-011 SHALL have port bypass, input, 1: 1 = ignore gain/offset.
REQ-012 SHALL have port in_valid, input, 1: sample strobe.
REQ-013 SHALL have port in_data, input, DATA_W: signed sample.
REQ-014 SHALL have port cfg_we, input, 1: parameter write strobe.
REQ-015 SHALL have port cfg_ch, input, 4: channel being written.
REQ-016 SHALL have port cfg_gain, input, GAIN_W: signed gain.
REQ-017 SHALL have port cfg_offset, input, DATA_W: signed offset.
REQ-018 SHALL have port out_valid, output, 1: result strobe.
REQ-019 SHALL have port out_data, output, OUT_W: calibrated signed result.
REQ-020 SHALL have port out_ch, output, 4: channel of the result.
REQ-021 SHALL have port out_last, output, 1: final result of the burst.
REQ-022 SHALL have port busy, output, 1: high in RUN and FLUSH.
REQ-023 SHALL have port done, output, 1: one-cycle burst-complete pulse.

Function
REQ-024 SHALL implement FSM states IDLE, RUN, FLUSH, DONE: start in IDLE with frame_len>0 -> RUN; start in IDLE with frame_len==0 -> DONE directly, producing no outputs; start outside IDLE is ignored.
REQ-025 SHALL in RUN accept every in_valid cycle, with gaps allowed; in_valid in IDLE, FLUSH or DONE is ignored; there is no backpressure.
REQ-026 SHALL tag accepted samples with a channel counter 0..CH_NUM-1 that wraps to 0 and increments a frame counter; both counters clear on entering RUN.
REQ-027 SHALL treat the sample with channel CH_NUM-1 of frame frame_len-1 as the last sample, and move RUN -> FLUSH on the cycle after it is accepted.
REQ-028 SHALL hold FLUSH until the pipeline is empty, then go to DONE; DONE lasts one cycle with done=1 and then returns to IDLE.
REQ-029 SHALL compute result = sat_OUT_W(((in_data + offset[ch]) * gain[ch]) >>> FRAC_W):
- sum is DATA_W+1 bits;
- product is full precision;
- the shift is arithmetic, truncating toward minus infinity;
- the result saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-030 SHALL, with bypass=1, output sat_OUT_W(in_data), sign-extended when OUT_W>DATA_W.
REQ-031 SHALL use a 3-stage pipeline (add/lookup, multiply, shift/saturate), so the result appears exactly 3 cycles after acceptance, with out_ch and out_last aligned to it.
REQ-032 SHALL store per-channel gain/offset in registers; cfg_we writes regardless of state, and writes with cfg_ch>=CH_NUM are ignored.
REQ-033 SHALL, when cfg_we and a sample of the same channel occur in the same cycle, process that sample with the old value; the new value applies from the next cycle.
REQ-034 SHALL on abort, from any state, go to IDLE next cycle, clear all pipeline valid bits (no further out_valid), and not assert done; abort wins over simultaneous start.
REQ-035 SHALL drive out_data, out_ch, out_last to zero whenever out_valid=0.

Reset
REQ-036 SHALL on rst_n low asynchronously set:
- FSM to IDLE;
- counters and pipeline valids to 0;
- out_valid, out_data, out_ch, out_last, busy, done to 0;
- every gain to 2^FRAC_W (1.0) and every offset to 0.
REQ-037 SHALL behave as an abort without done when reset is asserted mid-burst; the first start after release begins a fresh burst.

Verification
REQ-038 SHALL cover: ch0 gain 0x08000 (0.5), offset -200, in 1000 -> out_data 400, out_ch 0, 3 cycles after acceptance.
REQ-039 SHALL cover saturation: gain 0x20000 (2.0), in 32767 -> 32767; in -32768 -> -32768; gain 0.5, in -3 -> -2.
REQ-040 SHALL cover CH_NUM=8, frame_len=2, 16 samples with random gaps -> 16 out_valid, out_ch 0..7,0..7, out_last only on the 16th, a single done pulse 1 cycle after FSM leaves FLUSH, busy low afterwards.
REQ-041 SHALL cover start with frame_len=0 -> done one cycle after start, no out_valid; start during RUN -> ignored, counters unaffected.
REQ-042 SHALL cover abort after 5 samples -> at most 0 further out_valid, no done, busy low next cycle; the next burst starts at channel 0.
REQ-043 SHALL cover same-cycle cfg_we(ch3, gain 0.5) and a ch3 sample of 100 with gain 1.0 -> output 100, and the next ch3 sample of 100 -> 50; bypass=1, in -5 -> -5.

Source files
------------

// File: rtl/multi_ch_cail.sv
// Multi-channel gain/offset calibration: burst FSM, per-channel coefficient
// registers and a 3-stage add / multiply / shift-saturate datapath.
module multi_ch_cail #(
  parameter int CH_NUM = 8,
  parameter int DATA_W = 16,
  parameter int GAIN_W = 20,
  parameter int FRAC_W = 16,
  parameter int OUT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [15:0]              frame_len,
  input  logic                     abort,
  input  logic                     bypass,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     cfg_we,
  input  logic [3:0]               cfg_ch,
  input  logic signed [GAIN_W-1:0] cfg_gain,
  input  logic signed [DATA_W-1:0] cfg_offset,
  output logic                     out_valid,
  output logic signed [OUT_W-1:0]  out_data,
  output logic [3:0]               out_ch,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done
);
  localparam int SUM_W  = DATA_W + 1;
  localparam int PROD_W = SUM_W + GAIN_W;
  localparam logic [3:0] LAST_CH = 4'(CH_NUM - 1);
  localparam logic signed [GAIN_W-1:0] GAIN_ONE = GAIN_W'(1) << FRAC_W;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [PROD_W-1:0] x);
    logic signed [PROD_W-1:0] hi;
    logic signed [PROD_W-1:0] lo;
    hi = {{(PROD_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    lo = ~hi;
    if (x > hi)      return hi[OUT_W-1:0];
    else if (x < lo) return lo[OUT_W-1:0];
    else             return x[OUT_W-1:0];
  endfunction

  state_t                    state_q;
  logic [3:0]                ch_q;
  logic [15:0]               frame_q;
  logic [15:0]               flen_q;
  // Sized to the full 4-bit channel space so cfg_ch/ch_q index without truncation.
  logic signed [GAIN_W-1:0]  gain_q   [16];
  logic signed [DATA_W-1:0]  offset_q [16];

  logic                      vld_p0, vld_p1, last_p0, last_p1;
  logic [3:0]                ch_p0, ch_p1;
  logic signed [SUM_W-1:0]   sum_p0;
  logic signed [GAIN_W-1:0]  gain_p0;
  logic signed [PROD_W-1:0]  prod_p1;

  logic accept, last_smp, keep_p1;

  assign accept   = (state_q == RUN) && in_valid && !abort;
  assign last_smp = (ch_q == LAST_CH) && (frame_q == flen_q - 16'd1);
  assign keep_p1  = vld_p1 && !abort;

  // Coefficient registers: a write lands at the edge, so a same-cycle sample sees the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        gain_q[i]   <= GAIN_ONE;
        offset_q[i] <= '0;
      end
    end else if (cfg_we && (int'(cfg_ch) < CH_NUM)) begin
      gain_q[cfg_ch]   <= cfg_gain;
      offset_q[cfg_ch] <= cfg_offset;
    end
  end

  // FSM, counters, pipeline valids and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      frame_q   <= '0;
      flen_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      last_p0   <= 1'b0;
      last_p1   <= 1'b0;
      ch_p0     <= '0;
      ch_p1     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_last  <= 1'b0;
    end else begin
      if (abort) begin
        state_q <= IDLE;
        busy    <= 1'b0;
        done    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (start) begin
            if (frame_len == 16'd0) begin
              state_q <= DONE;
              done    <= 1'b1;
            end else begin
              state_q <= RUN;
              busy    <= 1'b1;
              ch_q    <= '0;
              frame_q <= '0;
              flen_q  <= frame_len;
            end
          end
          RUN: if (accept) begin
            if (last_smp) state_q <= FLUSH;
            if (ch_q == LAST_CH) begin
              ch_q    <= '0;
              frame_q <= frame_q + 16'd1;
            end else begin
              ch_q <= ch_q + 4'd1;
            end
          end
          FLUSH: if (!vld_p0 && !vld_p1) begin
            state_q <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
          default: begin
            state_q <= IDLE;
            done    <= 1'b0;
          end
        endcase
      end

      // stage p0: sample accepted
      vld_p0  <= accept;
      ch_p0   <= ch_q;
      last_p0 <= accept && last_smp;
      // stage p1: multiply
      vld_p1  <= vld_p0 && !abort;
      ch_p1   <= ch_p0;
      last_p1 <= last_p0;
      // stage p2: shift/saturate into output registers
      out_valid <= keep_p1;
      out_ch    <= keep_p1 ? ch_p1 : '0;
      out_last  <= keep_p1 && last_p1;
      out_data  <= keep_p1 ? sat_out(prod_p1 >>> FRAC_W) : '0;
    end
  end

  // Datapath registers; bypass runs the raw sample through the multiplier at unity gain.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (bypass) begin
        sum_p0  <= {in_data[DATA_W-1], in_data};
        gain_p0 <= GAIN_ONE;
      end else begin
        sum_p0  <= {in_data[DATA_W-1], in_data} + {offset_q[ch_q][DATA_W-1], offset_q[ch_q]};
        gain_p0 <= gain_q[ch_q];
      end
    end
    prod_p1 <= PROD_W'(sum_p0) * PROD_W'(gain_p0);
  end
endmodule

// File: tb/tb_multi_ch_cail.sv
// Self-checking bench for multi_ch_cail: directed scenarios plus randomized
// bursts scored against an arithmetic reference model.
module tb_multi_ch_cail;
  localparam int CH_NUM = 8;
  localparam int FRAC_W = 16;

  logic clk = 1'b0;
  logic rst_n, start, abort, bypass, in_valid, cfg_we;
  logic [15:0] frame_len;
  logic signed [15:0] in_data, cfg_offset, out_data;
  logic [3:0] cfg_ch, out_ch;
  logic signed [19:0] cfg_gain;
  logic out_valid, out_last, busy, done;

  int total = 0;
  int bad = 0;

  typedef struct { int due; logic signed [15:0] d; logic [3:0] ch; logic last; } exp_t;

  multi_ch_cail #(.CH_NUM(8), .DATA_W(16), .GAIN_W(20), .FRAC_W(16), .OUT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .frame_len(frame_len), .abort(abort),
    .bypass(bypass), .in_valid(in_valid), .in_data(in_data), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_gain(cfg_gain), .cfg_offset(cfg_offset),
    .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch), .out_last(out_last),
    .busy(busy), .done(done));

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic signed [15:0] ref_cal(int x, longint g, int off, bit byp);
    longint v;
    if (byp) v = x;
    else v = ((longint'(x) + longint'(off)) * g) >>> FRAC_W;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return 16'(v);
  endfunction

  task automatic idle_inputs();
    start = 0; abort = 0; bypass = 0; in_valid = 0; in_data = 0; frame_len = 0;
    cfg_we = 0; cfg_ch = 0; cfg_gain = 0; cfg_offset = 0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst_n = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic cfg_write(input int ch, input int g, input int o);
    cfg_we = 1; cfg_ch = 4'(ch); cfg_gain = 20'(g); cfg_offset = 16'(o);
    @(negedge clk);
    cfg_we = 0;
  endtask

  task automatic test_reset();
    logic signed [15:0] exp_d [8];
    idle_inputs();
    rst_n = 0;
    #1;
    total++;
    if ({out_valid, out_last, busy, done} !== 4'b0 || out_data !== 0 || out_ch !== 0) begin
      bad++; $display("FAIL reset_state: v=%b last=%b busy=%b done=%b d=%0d ch=%0d, want all 0", out_valid, out_last, busy, done, out_data, out_ch);
    end
    @(negedge clk); rst_n = 1; @(negedge clk);
    total++;
    if ({out_valid, busy, done} !== 3'b0) begin
      bad++; $display("FAIL reset_release: v=%b busy=%b done=%b, want 0 0 0", out_valid, busy, done);
    end
    start = 1; frame_len = 3; @(negedge clk); start = 0;
    for (int j = 0; j < 5; j++) begin
      in_valid = 1; in_data = 16'(j + 1); @(negedge clk);
    end
    total++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL midburst_running: v=%b busy=%b, want 1 1", out_valid, busy);
    end
    rst_n = 0; in_valid = 0;
    #1;
    total++;
    if (out_valid !== 0 || busy !== 0 || done !== 0 || out_data !== 0 || out_ch !== 0) begin
      bad++; $display("FAIL midburst_async_reset: v=%b busy=%b done=%b d=%0d ch=%0d, want 0", out_valid, busy, done, out_data, out_ch);
    end
    @(negedge clk); rst_n = 1; @(negedge clk);
    for (int k = 0; k < 8; k++) exp_d[k] = 16'(50 + 3 * k);
    start = 1; frame_len = 1; @(negedge clk); start = 0;
    for (int j = 0; j < 13; j++) begin
      if (j >= 3 && j < 11) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== exp_d[j-3] || out_ch !== 4'(j-3) || out_last !== (j == 10)) begin
          bad++; $display("FAIL fresh_burst[%0d]: v=%b d=%0d ch=%0d last=%b, want 1 %0d %0d %b", j-3, out_valid, out_data, out_ch, out_last, exp_d[j-3], j-3, j == 10);
        end
      end else begin
        total++;
        if (out_valid !== 0) begin bad++; $display("FAIL fresh_burst_idle[%0d]: v=%b, want 0", j, out_valid); end
      end
      in_valid = (j < 8); in_data = (j < 8) ? exp_d[j] : 16'sd0;
      @(negedge clk);
    end
  endtask

  task automatic test_gain_offset();
    int din [8];
    int expd [8];
    reset_dut();
    cfg_write(0, 'h08000, -200);
    cfg_write(1, 'h20000, 0);
    cfg_write(2, 'h20000, 0);
    cfg_write(3, 'h08000, 0);
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) begin
        din  = '{1000, 32767, -32768, -3, 11, -12, 300, -4000};
        expd = '{400, 32767, -32768, -2, 11, -12, 300, -4000};
      end else begin
        din  = '{-5, 32767, -32768, 100, -1, 0, 5, -7};
        expd = '{-5, 32767, -32768, 100, -1, 0, 5, -7};
      end
      bypass = (pass == 1);
      start = 1; frame_len = 1; @(negedge clk); start = 0;
      for (int j = 0; j < 13; j++) begin
        if (j >= 3 && j < 11) begin
          total++;
          if (out_valid !== 1'b1 || out_data !== 16'(expd[j-3]) || out_ch !== 4'(j-3) || out_last !== (j == 10)) begin
            bad++; $display("FAIL gain_offset p%0d[%0d]: v=%b d=%0d ch=%0d last=%b, want 1 %0d %0d %b", pass, j-3, out_valid, out_data, out_ch, out_last, expd[j-3], j-3, j == 10);
          end
        end else begin
          total++;
          if (out_valid !== 0 || out_data !== 0 || out_ch !== 0 || out_last !== 0) begin
            bad++; $display("FAIL gain_offset_quiet p%0d[%0d]: v=%b d=%0d ch=%0d last=%b, want zeros", pass, j, out_valid, out_data, out_ch, out_last);
          end
        end
        total++;
        if (busy !== (j <= 10) || done !== (j == 11)) begin
          bad++; $display("FAIL gain_offset_ctrl p%0d[%0d]: busy=%b done=%b, want %b %b", pass, j, busy, done, j <= 10, j == 11);
        end
        in_valid = (j < 8); in_data = (j < 8) ? 16'(din[j]) : 16'sd0;
        @(negedge clk);
      end
    end
    bypass = 0;
  endtask

  task automatic test_cfg_same_cycle();
    logic signed [15:0] din [16];
    logic signed [15:0] exp_d [16];
    reset_dut();
    cfg_write(9, 0, 0);
    for (int k = 0; k < 16; k++) begin
      din[k] = 16'($urandom_range(0, 2000)) - 16'sd1000;
      if (k == 1) din[k] = 16'sd77;
      if (k == 3 || k == 11) din[k] = 16'sd100;
      exp_d[k] = din[k];
    end
    exp_d[11] = 16'sd50;
    start = 1; frame_len = 2; @(negedge clk); start = 0;
    for (int j = 0; j < 21; j++) begin
      if (j >= 3 && j < 19) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== exp_d[j-3] || out_ch !== 4'((j-3) % CH_NUM) || out_last !== (j == 18)) begin
          bad++; $display("FAIL cfg_same_cycle[%0d]: v=%b d=%0d ch=%0d last=%b, want 1 %0d %0d %b", j-3, out_valid, out_data, out_ch, out_last, exp_d[j-3], (j-3) % CH_NUM, j == 18);
        end
      end
      total++;
      if (done !== (j == 19)) begin
        bad++; $display("FAIL cfg_same_cycle_done[%0d]: done=%b, want %b", j, done, j == 19);
      end
      cfg_we = (j == 3); cfg_ch = 4'd3; cfg_gain = 20'h08000; cfg_offset = 16'sd0;
      in_valid = (j < 16); in_data = (j < 16) ? din[j] : 16'sd0;
      @(negedge clk);
    end
    cfg_we = 0;
  endtask

  task automatic test_len0_and_start_in_run();
    logic signed [15:0] exp_d [8];
    reset_dut();
    start = 1; frame_len = 0; @(negedge clk); start = 0;
    for (int j = 0; j < 5; j++) begin
      total++;
      if (done !== (j == 0) || busy !== 0 || out_valid !== 0) begin
        bad++; $display("FAIL len0[%0d]: done=%b busy=%b v=%b, want %b 0 0", j, done, busy, out_valid, j == 0);
      end
      @(negedge clk);
    end
    for (int k = 0; k < 8; k++) exp_d[k] = 16'($urandom);
    start = 1; frame_len = 1; @(negedge clk); start = 0;
    for (int j = 0; j < 13; j++) begin
      if (j >= 3 && j < 11) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== exp_d[j-3] || out_ch !== 4'(j-3) || out_last !== (j == 10)) begin
          bad++; $display("FAIL start_in_run[%0d]: v=%b d=%0d ch=%0d last=%b, want 1 %0d %0d %b", j-3, out_valid, out_data, out_ch, out_last, exp_d[j-3], j-3, j == 10);
        end
      end
      total++;
      if (busy !== (j <= 10) || done !== (j == 11)) begin
        bad++; $display("FAIL start_in_run_ctrl[%0d]: busy=%b done=%b, want %b %b", j, busy, done, j <= 10, j == 11);
      end
      start = (j == 3); frame_len = (j == 3) ? 16'd5 : 16'd0;
      in_valid = (j < 8); in_data = (j < 8) ? exp_d[j] : 16'sd0;
      @(negedge clk);
    end
    start = 0;
  endtask

  task automatic test_abort();
    logic signed [15:0] exp_d [8];
    reset_dut();
    start = 1; frame_len = 2; @(negedge clk); start = 0;
    for (int j = 0; j < 14; j++) begin
      if (j >= 3 && j <= 5) begin
        total++;
        if (out_valid !== 1'b1 || out_ch !== 4'(j-3) || busy !== 1'b1) begin
          bad++; $display("FAIL abort_pre[%0d]: v=%b ch=%0d busy=%b, want 1 %0d 1", j, out_valid, out_ch, busy, j-3);
        end
      end else if (j >= 6) begin
        total++;
        if (out_valid !== 0 || done !== 0 || busy !== 0) begin
          bad++; $display("FAIL abort_post[%0d]: v=%b done=%b busy=%b, want 0 0 0", j, out_valid, done, busy);
        end
      end
      in_valid = (j < 5) || (j >= 9); in_data = 16'(j);
      abort = (j == 5) || (j == 8);
      start = (j == 8); frame_len = 16'd1;
      @(negedge clk);
    end
    in_valid = 0; abort = 0; start = 0;
    for (int k = 0; k < 8; k++) exp_d[k] = 16'(-k * 100);
    start = 1; frame_len = 1; @(negedge clk); start = 0;
    for (int j = 0; j < 13; j++) begin
      if (j >= 3 && j < 11) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== exp_d[j-3] || out_ch !== 4'(j-3) || out_last !== (j == 10)) begin
          bad++; $display("FAIL after_abort[%0d]: v=%b d=%0d ch=%0d last=%b, want 1 %0d %0d %b", j-3, out_valid, out_data, out_ch, out_last, exp_d[j-3], j-3, j == 10);
        end
      end
      total++;
      if (done !== (j == 11)) begin
        bad++; $display("FAIL after_abort_done[%0d]: done=%b, want %b", j, done, j == 11);
      end
      in_valid = (j < 8); in_data = (j < 8) ? exp_d[j] : 16'sd0;
      @(negedge clk);
    end
  endtask

  task automatic test_random_burst();
    longint gm [8];
    int om [8];
    exp_t q [$];
    exp_t e;
    int n, t, sent, nout, ndone, last_due, g, o;
    bit byp;
    logic signed [15:0] x;
    reset_dut();
    for (int b = 0; b < 4; b++) begin
      for (int c = 0; c < 8; c++) begin
        g = int'($urandom_range(0, 32'h3FFFF)) - 32'h20000;
        o = int'($urandom_range(0, 65535)) - 32768;
        gm[c] = g; om[c] = o;
        cfg_write(c, g, o);
      end
      n = (b == 0) ? 16 : 8 * int'($urandom_range(1, 3));
      byp = (b == 3);
      bypass = byp;
      start = 1; frame_len = 16'(n / 8); @(negedge clk); start = 0;
      t = 0; sent = 0; nout = 0; ndone = 0; last_due = -100;
      while (t < 400 && !(sent == n && q.size() == 0 && t > last_due + 2)) begin
        if (q.size() > 0 && q[0].due == t) begin
          e = q.pop_front();
          nout++;
          total++;
          if (out_valid !== 1'b1 || out_data !== e.d || out_ch !== e.ch || out_last !== e.last) begin
            bad++; $display("FAIL random b%0d t=%0d: v=%b d=%0d ch=%0d last=%b, want 1 %0d %0d %b", b, t, out_valid, out_data, out_ch, out_last, e.d, e.ch, e.last);
          end
        end else begin
          total++;
          if (out_valid !== 0 || out_data !== 0 || out_ch !== 0 || out_last !== 0) begin
            bad++; $display("FAIL random_quiet b%0d t=%0d: v=%b d=%0d ch=%0d last=%b, want zeros", b, t, out_valid, out_data, out_ch, out_last);
          end
        end
        if (done === 1'b1) begin
          ndone++;
          total++;
          if (sent != n || q.size() != 0 || nout != n) begin
            bad++; $display("FAIL random_early_done b%0d t=%0d: outputs=%0d, want %0d before done", b, t, nout, n);
          end
        end
        if (sent < n && $urandom_range(0, 2) != 0) begin
          case ($urandom_range(0, 3))
            0: x = 16'sd32767;
            1: x = -16'sd32768;
            default: x = 16'($urandom);
          endcase
          in_valid = 1; in_data = x;
          e.due = t + 3; e.ch = 4'(sent % CH_NUM); e.last = (sent == n - 1);
          e.d = ref_cal(int'(x), gm[sent % CH_NUM], om[sent % CH_NUM], byp);
          q.push_back(e);
          if (sent == n - 1) last_due = t + 3;
          sent++;
        end else begin
          in_valid = 0; in_data = 0;
        end
        @(negedge clk);
        t++;
      end
      in_valid = 0;
      total++;
      if (t >= 400 || ndone != 1 || nout != n) begin
        bad++; $display("FAIL random_summary b%0d: cycles=%0d done_pulses=%0d outputs=%0d, want <400 1 %0d", b, t, ndone, nout, n);
      end
      total++;
      if (busy !== 0 || done !== 0) begin
        bad++; $display("FAIL random_after b%0d: busy=%b done=%b, want 0 0", b, busy, done);
      end
    end
    bypass = 0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    test_reset();
    test_gain_offset();
    test_cfg_same_cycle();
    test_len0_and_start_in_run();
    test_abort();
    test_random_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
